// File: rtl/pc_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_pkg
// Description : Shared types and constants for the PC generation stage:
//               address bus type, BTB 2-bit counter type and encodings,
//               next-PC source select and the saturating counter helper.
// Revision    : 1.0 - initial release
// ============================================================================
package pc_gen_pkg;

    localparam int ADDR_BUS_WIDTH = 32;
    typedef logic [ADDR_BUS_WIDTH-1:0] ADDR_BUS;

    typedef logic [1:0] BTB_CNT_BUS;
    localparam BTB_CNT_BUS BTB_CNT_STRONG_NOT_TAKEN = 2'b00;
    localparam BTB_CNT_BUS BTB_CNT_WEAK_NOT_TAKEN   = 2'b01;
    localparam BTB_CNT_BUS BTB_CNT_WEAK_TAKEN       = 2'b10;
    localparam BTB_CNT_BUS BTB_CNT_STRONG_TAKEN     = 2'b11;

    // Next-PC source, listed from highest to lowest priority.
    typedef enum logic [2:0] {
        NPC_FLUSH    = 3'd0,
        NPC_REDIRECT = 3'd1,
        NPC_HOLD     = 3'd2,
        NPC_PRED     = 3'd3,
        NPC_SEQ      = 3'd4
    } npc_sel_e;

    // Two-bit saturating counter step toward the resolved direction.
    function automatic BTB_CNT_BUS btb_cnt_next(input BTB_CNT_BUS cnt, input logic taken);
        BTB_CNT_BUS res;
        res = cnt;
        if (taken) begin
            if (cnt != BTB_CNT_STRONG_TAKEN) res = cnt + 2'd1;
        end else begin
            if (cnt != BTB_CNT_STRONG_NOT_TAKEN) res = cnt - 2'd1;
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_gen_btb.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen_btb
// Description : Direct-mapped branch target buffer. Combinational lookup on
//               the current fetch PC, trained on the clock edge by the
//               backend. Entries are keyed by the delay-slot PC.
// Ports       : clk, rst (async, active-low)
//               i_lookup_pc      - PC being fetched
//               o_pred_taken     - hit with counter in a taken state
//               o_pred_target    - stored target on hit, else lookup PC + 4
//               i_update_valid / i_update_pc / i_update_target /
//               i_update_taken   - training interface
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen_btb
    import pc_gen_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  ADDR_BUS i_lookup_pc,
    output logic    o_pred_taken,
    output ADDR_BUS o_pred_target,
    input  logic    i_update_valid,
    input  ADDR_BUS i_update_pc,
    input  ADDR_BUS i_update_target,
    input  logic    i_update_taken
);

    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = ADDR_BUS_WIDTH - IDX_W - 2;

    logic [BTB_ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]       r_tag    [BTB_ENTRIES];
    ADDR_BUS                r_target [BTB_ENTRIES];
    BTB_CNT_BUS             r_cnt    [BTB_ENTRIES];

    logic [IDX_W-1:0] w_lk_idx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_idx;
    logic [TAG_W-1:0] w_up_tag;
    logic             w_up_hit;

    // Byte-offset bits are not part of index or tag; alignment is checked downstream.
    logic w_unused_offset;
    assign w_unused_offset = &{1'b0, i_lookup_pc[1:0], i_update_pc[1:0]};

    assign w_lk_idx = i_lookup_pc[IDX_W+1:2];
    assign w_lk_tag = i_lookup_pc[ADDR_BUS_WIDTH-1:IDX_W+2];
    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);

    // Lookup reads the registered state, so an update to the same index in
    // this cycle only becomes visible after the edge.
    assign o_pred_taken  = w_lk_hit && r_cnt[w_lk_idx][1];
    assign o_pred_target = w_lk_hit ? r_target[w_lk_idx] : i_lookup_pc + 32'd4;

    assign w_up_idx = i_update_pc[IDX_W+1:2];
    assign w_up_tag = i_update_pc[ADDR_BUS_WIDTH-1:IDX_W+2];
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == w_up_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
            for (int i = 0; i < BTB_ENTRIES; i++) begin
                r_tag[i]    <= '0;
                r_target[i] <= '0;
                r_cnt[i]    <= BTB_CNT_WEAK_NOT_TAKEN;
            end
        end else if (i_update_valid) begin
            if (w_up_hit) begin
                r_cnt[w_up_idx] <= btb_cnt_next(r_cnt[w_up_idx], i_update_taken);
                if (i_update_taken) begin
                    r_target[w_up_idx] <= i_update_target;
                end
            end else if (i_update_taken) begin
                // Miss on a taken branch replaces whatever lived at this index.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= w_up_tag;
                r_target[w_up_idx] <= i_update_target;
                r_cnt[w_up_idx]    <= BTB_CNT_WEAK_TAKEN;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : pc_gen
// Description : Front-of-pipeline PC generation. Holds the fetch PC and
//               selects the next PC from flush, redirect, stall-hold, BTB
//               prediction or sequential (+4) sources.
// Ports       : clk, rst (async, active-low)
//               stall_current_stage        - hold the PC
//               flush / flush_pc           - exception/ERET redirect (top priority)
//               redirect_valid/redirect_pc - execute-stage mispredict redirect
//               update_*                   - BTB training from the backend
//               pc_out                     - current fetch PC
//               pred_taken / pred_target   - BTB prediction for pc_out
// Revision    : 1.0 - initial release
// ============================================================================
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter ADDR_BUS RESET_PC    = 32'hBFC0_0000,
    parameter int      BTB_ENTRIES = 16
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    stall_current_stage,
    input  logic    flush,
    input  ADDR_BUS flush_pc,
    input  logic    redirect_valid,
    input  ADDR_BUS redirect_pc,
    input  logic    update_valid,
    input  ADDR_BUS update_pc,
    input  ADDR_BUS update_target,
    input  logic    update_taken,
    output ADDR_BUS pc_out,
    output logic    pred_taken,
    output ADDR_BUS pred_target
);

    ADDR_BUS  r_pc;
    ADDR_BUS  w_next_pc;
    npc_sel_e w_npc_sel;
    logic     w_pred_taken;
    ADDR_BUS  w_pred_target;

    pc_gen_btb #(
        .BTB_ENTRIES (BTB_ENTRIES)
    ) u_btb (
        .clk             (clk),
        .rst             (rst),
        .i_lookup_pc     (r_pc),
        .o_pred_taken    (w_pred_taken),
        .o_pred_target   (w_pred_target),
        .i_update_valid  (update_valid),
        .i_update_pc     (update_pc),
        .i_update_target (update_target),
        .i_update_taken  (update_taken)
    );

    // Flush and redirect come from later stages and must win over a stall.
    always_comb begin
        w_npc_sel = NPC_SEQ;
        if (flush) begin
            w_npc_sel = NPC_FLUSH;
        end else if (redirect_valid) begin
            w_npc_sel = NPC_REDIRECT;
        end else if (stall_current_stage) begin
            w_npc_sel = NPC_HOLD;
        end else if (w_pred_taken) begin
            w_npc_sel = NPC_PRED;
        end
    end

    always_comb begin
        w_next_pc = r_pc + 32'd4;
        case (w_npc_sel)
            NPC_FLUSH:    w_next_pc = flush_pc;
            NPC_REDIRECT: w_next_pc = redirect_pc;
            NPC_HOLD:     w_next_pc = r_pc;
            NPC_PRED:     w_next_pc = w_pred_target;
            default:      w_next_pc = r_pc + 32'd4;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc <= RESET_PC;
        end else begin
            r_pc <= w_next_pc;
        end
    end

    assign pc_out      = r_pc;
    assign pred_taken  = w_pred_taken;
    assign pred_target = w_pred_target;

endmodule
`default_nettype wire

// File: tb/tb_pc_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_gen
// Description : Self-checking bench for pc_gen: directed vector table,
//               hand-written corner sequences and a randomized run checked
//               against a behavioural next-PC / BTB model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_gen;

    localparam logic [31:0] RST_PC = 32'hBFC0_0000;
    localparam int          NENT   = 16;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        flush;
    logic [31:0] flush_pc;
    logic        redir;
    logic [31:0] redir_pc;
    logic        upd_v;
    logic [31:0] upd_pc;
    logic [31:0] upd_tgt;
    logic        upd_taken;
    logic [31:0] pc_out;
    logic        pred_taken;
    logic [31:0] pred_target;

    int n_checks = 0;
    int n_errors = 0;

    pc_gen #(
        .RESET_PC    (RST_PC),
        .BTB_ENTRIES (NENT)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .stall_current_stage (stall),
        .flush               (flush),
        .flush_pc            (flush_pc),
        .redirect_valid      (redir),
        .redirect_pc         (redir_pc),
        .update_valid        (upd_v),
        .update_pc           (upd_pc),
        .update_target       (upd_tgt),
        .update_taken        (upd_taken),
        .pc_out              (pc_out),
        .pred_taken          (pred_taken),
        .pred_target         (pred_target)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=%08h expected=%08h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] e_pc,
                           input logic e_pt, input logic [31:0] e_tgt);
        chk({name, ".pc_out"},      pc_out,              e_pc);
        chk({name, ".pred_taken"},  {31'b0, pred_taken}, {31'b0, e_pt});
        chk({name, ".pred_target"}, pred_target,         e_tgt);
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; flush_pc = '0; redir = 0; redir_pc = '0;
        upd_v = 0; upd_pc = '0; upd_tgt = '0; upd_taken = 0;
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        s;
        logic        f;
        logic [31:0] fpc;
        logic        r;
        logic [31:0] rpc;
        logic        u;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        utk;
        logic [31:0] e_pc;
        logic        e_pt;
        logic [31:0] e_tgt;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic s, input logic f, input logic [31:0] fpc,
                                input logic r, input logic [31:0] rpc,
                                input logic u, input logic [31:0] upc,
                                input logic [31:0] utgt, input logic utk,
                                input logic [31:0] e_pc, input logic e_pt,
                                input logic [31:0] e_tgt);
        vec_t v;
        v.s = s; v.f = f; v.fpc = fpc; v.r = r; v.rpc = rpc;
        v.u = u; v.upc = upc; v.utgt = utgt; v.utk = utk;
        v.e_pc = e_pc; v.e_pt = e_pt; v.e_tgt = e_tgt;
        return v;
    endfunction

    // ---------------- behavioural reference model ----------------
    logic        m_valid [NENT];
    logic [31:0] m_tagv  [NENT];
    logic [31:0] m_tgt   [NENT];
    int          m_cnt   [NENT];
    logic [31:0] m_pc;

    function automatic int m_idx(input logic [31:0] pc);
        return int'((pc / 32'd4) % 32'(NENT));
    endfunction

    function automatic logic [31:0] m_tag(input logic [31:0] pc);
        return pc / (32'd4 * 32'(NENT));
    endfunction

    function automatic logic m_hit(input logic [31:0] pc);
        return m_valid[m_idx(pc)] && (m_tagv[m_idx(pc)] == m_tag(pc));
    endfunction

    function automatic logic m_pt(input logic [31:0] pc);
        return m_hit(pc) && (m_cnt[m_idx(pc)] >= 2);
    endfunction

    function automatic logic [31:0] m_ptgt(input logic [31:0] pc);
        return m_hit(pc) ? m_tgt[m_idx(pc)] : pc + 32'd4;
    endfunction

    task automatic model_reset();
        m_pc = RST_PC;
        for (int i = 0; i < NENT; i++) begin
            m_valid[i] = 0; m_tagv[i] = '0; m_tgt[i] = '0; m_cnt[i] = 1;
        end
    endtask

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        logic [31:0] nxt;
        int          ui;
        if (flush)               nxt = flush_pc;
        else if (redir)          nxt = redir_pc;
        else if (stall)          nxt = m_pc;
        else if (m_pt(m_pc))     nxt = m_ptgt(m_pc);
        else                     nxt = m_pc + 32'd4;
        if (upd_v) begin
            ui = m_idx(upd_pc);
            if (m_hit(upd_pc)) begin
                if (upd_taken) begin
                    m_cnt[ui] = (m_cnt[ui] >= 3) ? 3 : m_cnt[ui] + 1;
                    m_tgt[ui] = upd_tgt;
                end else begin
                    m_cnt[ui] = (m_cnt[ui] <= 0) ? 0 : m_cnt[ui] - 1;
                end
            end else if (upd_taken) begin
                m_valid[ui] = 1;
                m_tagv[ui]  = m_tag(upd_pc);
                m_tgt[ui]   = upd_tgt;
                m_cnt[ui]   = 2;
            end
        end
        m_pc = nxt;
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        case ($urandom_range(0, 2))
            0:       base = 32'h0040_0000;
            1:       base = 32'hBFC0_0000;
            default: base = 32'hFFFF_FFC0;
        endcase
        // Small offsets plus an occasional +64 create index aliases with other tags.
        return base + 32'($urandom_range(0, 15) * 4) + 32'($urandom_range(0, 1) * 64);
    endfunction

    initial begin
        vecs[0]  = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00004,0,32'hBFC00008);
        vecs[1]  = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00008,0,32'hBFC0000C);
        vecs[2]  = mk(1,0,0,0,0,0,0,0,0, 32'hBFC00008,0,32'hBFC0000C);
        vecs[3]  = mk(1,0,0,0,0,0,0,0,0, 32'hBFC00008,0,32'hBFC0000C);
        vecs[4]  = mk(1,1,32'h80000180,0,0,0,0,0,0, 32'h80000180,0,32'h80000184);
        vecs[5]  = mk(0,1,32'h80000180,1,32'h80001000,0,0,0,0, 32'h80000180,0,32'h80000184);
        vecs[6]  = mk(0,0,0,1,32'h80001000,0,0,0,0, 32'h80001000,0,32'h80001004);
        vecs[7]  = mk(1,0,0,0,0,1,32'hBFC00014,32'hBFC00100,1, 32'h80001000,0,32'h80001004);
        vecs[8]  = mk(0,1,32'hBFC00000,0,0,0,0,0,0, 32'hBFC00000,0,32'hBFC00004);
        vecs[9]  = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00004,0,32'hBFC00008);
        vecs[10] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00008,0,32'hBFC0000C);
        vecs[11] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC0000C,0,32'hBFC00010);
        vecs[12] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00010,0,32'hBFC00014);
        vecs[13] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00014,1,32'hBFC00100);
        vecs[14] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00100,0,32'hBFC00104);
        vecs[15] = mk(0,1,32'hBFC00014,0,0,1,32'hBFC00014,32'h0,0, 32'hBFC00014,0,32'hBFC00100);
        vecs[16] = mk(1,0,0,0,0,1,32'hBFC00014,32'h0,0, 32'hBFC00014,0,32'hBFC00100);
        vecs[17] = mk(0,0,0,0,0,0,0,0,0, 32'hBFC00018,0,32'hBFC0001C);
        vecs[18] = mk(0,1,32'hBFC00054,0,0,0,0,0,0, 32'hBFC00054,0,32'hBFC00058);
        vecs[19] = mk(1,0,0,0,0,1,32'hBFC00054,32'h12345678,1, 32'hBFC00054,1,32'h12345678);
        vecs[20] = mk(0,0,0,0,0,0,0,0,0, 32'h12345678,0,32'h1234567C);
        vecs[21] = mk(0,1,32'hFFFFFFFC,0,0,0,0,0,0, 32'hFFFFFFFC,0,32'h00000000);
        vecs[22] = mk(0,0,0,0,0,0,0,0,0, 32'h00000000,0,32'h00000004);

        // ---- asynchronous reset, no clock edge needed ----
        idle_inputs();
        rst = 1'b1;
        #2 rst = 1'b0;
        #1 chk_out("reset_async", RST_PC, 1'b0, RST_PC + 32'd4);
        edge1();
        edge1();
        rst = 1'b1;
        #1 chk_out("reset_release", RST_PC, 1'b0, RST_PC + 32'd4);

        // ---- directed table ----
        for (int v = 0; v < NVEC; v++) begin
            stall = vecs[v].s; flush = vecs[v].f; flush_pc = vecs[v].fpc;
            redir = vecs[v].r; redir_pc = vecs[v].rpc;
            upd_v = vecs[v].u; upd_pc = vecs[v].upc; upd_tgt = vecs[v].utgt;
            upd_taken = vecs[v].utk;
            edge1();
            chk_out($sformatf("vec%0d", v), vecs[v].e_pc, vecs[v].e_pt, vecs[v].e_tgt);
        end
        idle_inputs();

        // ---- reset mid-operation discards BTB history (0xBFC00054 was trained) ----
        rst = 1'b0;
        #1 chk_out("midreset", RST_PC, 1'b0, RST_PC + 32'd4);
        edge1();
        rst = 1'b1;
        flush = 1; flush_pc = 32'hBFC00054;
        edge1();
        idle_inputs();
        chk_out("midreset_history", 32'hBFC00054, 1'b0, 32'hBFC00058);

        // ---- update and lookup of the same index in one cycle ----
        stall = 1; upd_v = 1; upd_pc = 32'hBFC00054; upd_tgt = 32'h11110000; upd_taken = 1;
        #1 chk_out("same_cycle_old", 32'hBFC00054, 1'b0, 32'hBFC00058);
        edge1();
        idle_inputs();
        chk_out("same_cycle_new", 32'hBFC00054, 1'b1, 32'h11110000);
        edge1();
        chk("same_cycle_follow.pc_out", pc_out, 32'h11110000);

        // ---- randomized run against the reference model ----
        rst = 1'b0;
        model_reset();
        edge1();
        rst = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) begin
                rst = 1'b0;
                model_reset();
                #1 rst = 1'b1;
            end
            stall     = ($urandom_range(0, 3) == 0);
            flush     = ($urandom_range(0, 15) == 0);
            flush_pc  = rand_pc();
            redir     = ($urandom_range(0, 7) == 0);
            redir_pc  = rand_pc();
            upd_v     = ($urandom_range(0, 2) == 0);
            upd_pc    = ($urandom_range(0, 1) == 0) ? m_pc : rand_pc();
            upd_tgt   = rand_pc();
            upd_taken = ($urandom_range(0, 2) != 0);
            #1;
            chk_out("rand", m_pc, m_pt(m_pc), m_ptgt(m_pc));
            model_step();
            edge1();
        end
        idle_inputs();
        #1 chk_out("rand_final", m_pc, m_pt(m_pc), m_ptgt(m_pc));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
